// File: rtl/pl_elastic_stage.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry skid buffer.
// Only the control field is scrubbed on flush; a saturating counter tracks stalls.
module pl_elastic_stage #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  // state | meaning
  // EMPTY | no entry held, out_ctrl reads 0
  // ONE   | head (main) valid
  // TWO   | head and skid valid, skid is the younger entry
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic                accept;
  logic                pop;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (accept) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (pop) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // Clear wins over increment; a flush cycle is not counted as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pl_elastic_stage.sv
// Self-checking bench for pl_elastic_stage: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_pl_elastic_stage;
  localparam int DW = 96;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          nRST = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic          out_ready = 1'b0;
  logic          stall_clr = 1'b0;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  logic          in_ready3, out_valid3;
  logic [DW-1:0] out_data3;
  logic [CW-1:0] out_ctrl3;
  logic [1:0]    occupancy3;
  logic [2:0]    stall_cnt3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] last_head;
  int unsigned   m_cnt16, m_cnt3;

  always #5 CLK = ~CLK;

  pl_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pl_elastic_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(3)) dut3 (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3), .out_ctrl(out_ctrl3),
    .occupancy(occupancy3), .stall_cnt(stall_cnt3), .stall_clr(stall_clr)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare();
    int n;
    n = q.size();
    chk("out_valid", out_valid, (n != 0));
    chk("in_ready", in_ready, (n < 2));
    chk("occupancy", occupancy, n);
    chk("out_ctrl", out_ctrl, (n != 0) ? q[0].c : '0);
    chk("out_data", out_data, (n != 0) ? q[0].d : last_head);
    chk("stall_cnt", stall_cnt, m_cnt16);
    chk("stall_cnt3", stall_cnt3, m_cnt3);
  endtask

  task automatic model_reset();
    q.delete();
    last_head = '0;
    m_cnt16 = 0;
    m_cnt3 = 0;
  endtask

  // Evaluated at the clock edge using the inputs driven for this cycle.
  task automatic model_update();
    bit acc, pp, stalled;
    ent_t e;
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    stalled = (q.size() > 0) && !out_ready && !flush;
    if (stall_clr) begin
      m_cnt16 = 0;
      m_cnt3 = 0;
    end else if (stalled) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
    end
    if (q.size() > 0) last_head = q[0].d;
  endtask

  // Called at a negedge: drive inputs, clock once, check at the next negedge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                     input bit ordy, input bit fl, input bit clr);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    stall_clr = clr;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
    compare();
  endtask

  // Asserted mid low-phase so outputs must clear without any clock edge.
  task automatic do_reset();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    compare();
    in_valid = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    compare();
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    do_reset();

    // Single entry with immediate drain
    cyc(1, 96'hA5, 8'h81, 1, 0, 0);
    chk("tp1_data", out_data, 96'hA5);
    chk("tp1_ctrl", out_ctrl, 8'h81);
    cyc(0, '0, '0, 1, 0, 0);
    chk("tp1_empty_ctrl", out_ctrl, 8'h00);

    // Fill the skid buffer, third push refused, then drain in order
    cyc(1, 96'h11, 8'h01, 0, 0, 0);
    cyc(1, 96'h22, 8'h02, 0, 0, 0);
    chk("tp2_full", in_ready, 1'b0);
    cyc(1, 96'h33, 8'h03, 0, 0, 0);
    cyc(0, '0, '0, 1, 0, 0);
    chk("tp2_second", out_data, 96'h22);
    chk("tp2_ready", in_ready, 1'b1);
    cyc(0, '0, '0, 1, 0, 0);

    // Flush while full with a concurrent push
    cyc(1, 96'hDEAD, 8'hFF, 0, 0, 1);
    cyc(1, 96'hBEEF, 8'h0F, 0, 0, 0);
    cyc(1, 96'hC0DE, 8'h55, 0, 1, 0);
    chk("tp3_occ", occupancy, 2'd0);
    chk("tp3_data_kept", out_data, 96'hDEAD);

    // Stall counting, clear, and 3-bit saturation
    cyc(1, 96'h44, 8'h04, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, '0, '0, 0, 0, 0);
    chk("tp4_five", stall_cnt, 16'd5);
    cyc(0, '0, '0, 0, 0, 1);
    chk("tp4_clr", stall_cnt, 16'd0);
    for (int i = 0; i < 10; i++) cyc(0, '0, '0, 0, 0, 0);
    chk("tp4_sat3", stall_cnt3, 3'd7);
    chk("tp4_ten", stall_cnt, 16'd10);
    cyc(0, '0, '0, 1, 0, 0);

    // Full-rate streaming
    for (int i = 0; i < 32; i++) cyc(1, DW'(i), CW'(i + 1), 1, 0, 0);
    chk("tp5_last", out_data, 96'd31);
    cyc(0, '0, '0, 1, 0, 0);

    // Async reset while holding two entries
    cyc(1, 96'h77, 8'h07, 0, 0, 0);
    cyc(1, 96'h88, 8'h08, 0, 0, 0);
    chk("tp6_pre_occ", occupancy, 2'd2);
    do_reset();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 9) < 7), {$urandom(), $urandom(), $urandom()}, CW'($urandom()),
          ($urandom_range(0, 9) < 5), ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
